note_player: RTL



---
 rtl/note_player.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/note_player.sv
// note_player: plays a fixed-length square-wave tone on each click that
// carries a valid note code, then leaves a short silent gap.
//
// Ports
//   CLOCK_50                 system clock
//   reset                    synchronous, active-high reset
//   note_num[5:0]            note code from the mouse-to-note stage
//   outc                     click level, qualified by note_num
//   audio_out_allowed        codec output FIFO has room
//   write_audio_out          sample write strobe (mirrors audio_out_allowed)
//   left_channel_audio_out   left sample (+AMP / -AMP / 0)
//   right_channel_audio_out  right sample, identical to left
//   playing                  high while a tone is sounding
//   cur_note[5:0]            note being played or just played; 0 when idle
//
// Handshake: a sample is presented continuously on the channel outputs and
// is consumed on every cycle where write_audio_out (= audio_out_allowed) is
// high. The sample never stalls and tone timing never depends on the codec.
//
// The HP_* parameters are the half-period, in cycles, for each valid note.
module note_player #(
  parameter int unsigned     DW         = 32,
  parameter logic [DW-1:0]   AMP        = DW'(32'h0080_0000),
  parameter int unsigned     DUR_CYCLES = 25_000_000,
  parameter int unsigned     GAP_CYCLES = 2_500_000,
  parameter int unsigned     HP_22      = 37921,
  parameter int unsigned     HP_25      = 45097,
  parameter int unsigned     HP_29      = 56818,
  parameter int unsigned     HP_32      = 63776
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [5:0]    note_num,
  input  logic          outc,
  input  logic          audio_out_allowed,
  output logic          write_audio_out,
  output logic [DW-1:0] left_channel_audio_out,
  output logic [DW-1:0] right_channel_audio_out,
  output logic          playing,
  output logic [5:0]    cur_note
);

  localparam int unsigned DUR_W = $clog2(DUR_CYCLES);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] NEG_AMP = DW'(~AMP + 1'b1);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  state_t           state, state_next;
  logic             outc_d;
  logic             armed;
  logic             phase;
  logic [16:0]      hp_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             pend;
  logic [5:0]       pend_note;
  logic [DW-1:0]    sample;
  logic             trig;
  logic             load_tone;
  logic [5:0]       tone_note;

  function automatic logic note_valid(input logic [5:0] n);
    return (n == 6'd22) || (n == 6'd25) || (n == 6'd29) || (n == 6'd32);
  endfunction

  // Reload value is half-period minus one so each phase lasts HP cycles.
  function automatic logic [16:0] half_reload(input logic [5:0] n);
    case (n)
      6'd22:   half_reload = 17'(HP_22 - 1);
      6'd25:   half_reload = 17'(HP_25 - 1);
      6'd29:   half_reload = 17'(HP_29 - 1);
      6'd32:   half_reload = 17'(HP_32 - 1);
      default: half_reload = '0;
    endcase
  endfunction

  // armed blocks a click whose level was already high when reset released;
  // outc must be seen low before the next rising edge can trigger.
  assign trig = outc & ~outc_d & armed & note_valid(note_num);

  always_comb begin
    state_next = state;
    load_tone  = 1'b0;
    tone_note  = note_num;
    case (state)
      IDLE: begin
        if (trig) begin
          state_next = PLAY;
          load_tone  = 1'b1;
        end
      end
      PLAY: begin
        // A retrigger wins over duration expiry.
        if (trig) begin
          load_tone = 1'b1;
        end else if (dur_cnt == '0) begin
          state_next = GAP;
        end
      end
      GAP: begin
        // A click in the last gap cycle still counts as the pending note.
        if (gap_cnt == '0) begin
          if (trig || pend) begin
            state_next = PLAY;
            load_tone  = 1'b1;
            tone_note  = trig ? note_num : pend_note;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      outc_d    <= 1'b0;
      armed     <= ~outc;
      phase     <= 1'b0;
      hp_cnt    <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      pend      <= 1'b0;
      pend_note <= '0;
      cur_note  <= '0;
      sample    <= '0;
    end else begin
      state  <= state_next;
      outc_d <= outc;
      if (!outc) armed <= 1'b1;

      // Sample reflects the state/phase of the current cycle, one cycle late.
      sample <= (state == PLAY) ? (phase ? AMP : NEG_AMP) : '0;

      if (load_tone) begin
        cur_note <= tone_note;
        hp_cnt   <= half_reload(tone_note);
        dur_cnt  <= DUR_W'(DUR_CYCLES - 1);
        phase    <= 1'b1;
      end else if (state == PLAY) begin
        if (hp_cnt == '0) begin
          hp_cnt <= half_reload(cur_note);
          phase  <= ~phase;
        end else begin
          hp_cnt <= hp_cnt - 1'b1;
        end
        if (dur_cnt == '0) begin
          gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        end else begin
          dur_cnt <= dur_cnt - 1'b1;
        end
      end

      if (state == GAP) begin
        if (gap_cnt == '0) begin
          pend <= 1'b0;
          if (!(trig || pend)) cur_note <= '0;
        end else begin
          gap_cnt <= gap_cnt - 1'b1;
          if (trig) begin
            pend      <= 1'b1;
            pend_note <= note_num;
          end
        end
      end
    end
  end

  assign write_audio_out         = audio_out_allowed;
  assign left_channel_audio_out  = sample;
  assign right_channel_audio_out = sample;
  assign playing                 = (state == PLAY);

endmodule
